// File: rtl/led_sequencer.sv
// led_sequencer: front-panel LED pattern generator.
//
// Drives NUM_LEDS registered outputs in one of four modes selected by
// `mode`: off, chase, blink and maintenance (all on). Pattern steps are
// paced by an internal prescaler tick every CLOCK_DIV system clocks, so
// the whole block runs on `clock` with no derived clock.
//
// Build option:
//   LED_SEQ_BOUNCE_EN  defined   -> chase runs ping-pong (0..N-1..0), using a
//                                   direction bit
//                      undefined -> chase wraps from N-1 back to 0
//
// Any change of `mode` restarts the prescaler and the pattern from position 0
// on the next clock. The restart wins over a coincident tick and over `hold`.

module led_sequencer #(
  parameter int NUM_LEDS  = 6,
  parameter int CLOCK_DIV = 10000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_enable,
  input  logic [1:0]          mode,
  input  logic                hold,
  output logic [NUM_LEDS-1:0] led_output,
  output logic                step_pulse
);

  // Prescaler needs at least one bit, even when CLOCK_DIV is 1.
  localparam int DIV_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam int POS_W = $clog2(NUM_LEDS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_CHASE = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_MAINT = 2'b11;

  // Registered state
  logic [DIV_W-1:0]    div_cnt;
  logic [POS_W-1:0]    pos;
  logic                phase;
  logic [1:0]          mode_q;

  // Next-state values
  logic [DIV_W-1:0]    div_cnt_n;
  logic [POS_W-1:0]    pos_n;
  logic                phase_n;
  logic [NUM_LEDS-1:0] led_n;

  // Control
  logic                restart;
  logic                tick;
  logic                step;
  logic                clear;

`ifdef LED_SEQ_BOUNCE_EN
  // Chase direction: 0 = counting up, 1 = counting down.
  logic                dir;
  logic                dir_n;
`endif

  // Restart detection and prescaler tick qualification.
  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    restart = (mode != mode_q);
    tick    = (div_cnt == DIV_LAST) && !hold;
    // Off mode parks everything at 0; a restart also clears everything.
    clear   = restart || (mode == MODE_OFF);
    // A restart suppresses a coincident tick; off mode never steps.
    step    = tick && !clear;
  end

  // Prescaler: counts 0..CLOCK_DIV-1, frozen by hold, cleared on restart/off.
  always_comb begin
    div_cnt_n = div_cnt;
    if (clear) begin
      div_cnt_n = '0;
    end else if (!hold) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt_n = '0;
      end else begin
        div_cnt_n = div_cnt + DIV_W'(1);
      end
    end
  end

  // Chase position: advances on each step while in chase mode.
  always_comb begin
    pos_n = pos;
`ifdef LED_SEQ_BOUNCE_EN
    dir_n = dir;
`endif
    if (clear) begin
      pos_n = '0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_n = 1'b0;
`endif
    end else if (step && (mode == MODE_CHASE)) begin
`ifdef LED_SEQ_BOUNCE_EN
      // Ping-pong: flip direction on the step that lands on either end,
      // so the end positions are shown once, not twice.
      if (!dir) begin
        pos_n = pos + POS_W'(1);
        if (pos_n == POS_LAST) begin
          dir_n = 1'b1;
        end
      end else begin
        pos_n = pos - POS_W'(1);
        if (pos_n == '0) begin
          dir_n = 1'b0;
        end
      end
`else
      // Wrap-around chase.
      if (pos == POS_LAST) begin
        pos_n = '0;
      end else begin
        pos_n = pos + POS_W'(1);
      end
`endif
    end
  end

  // Blink phase: toggles on each step while in blink mode.
  always_comb begin
    phase_n = phase;
    if (clear) begin
      phase_n = 1'b0;
    end else if (step && (mode == MODE_BLINK)) begin
      phase_n = ~phase;
    end
  end

  // Output pattern, computed from the next position/phase so that a step
  // and the LED update it causes become visible on the same clock edge.
  always_comb begin
    led_n = '0;
    case (mode)
      MODE_OFF:   led_n = '0;
      MODE_CHASE: led_n = (NUM_LEDS'(1) << pos_n) & led_enable;
      MODE_BLINK: led_n = phase_n ? led_enable : '0;
      MODE_MAINT: led_n = '1;
      default:    led_n = '0;
    endcase
  end

  // State and output registers; everything clears at once on reset low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      pos        <= '0;
      phase      <= 1'b0;
      mode_q     <= MODE_OFF;
      led_output <= '0;
      step_pulse <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_n;
      pos        <= pos_n;
      phase      <= phase_n;
      mode_q     <= mode;
      led_output <= led_n;
      step_pulse <= step;
    end
  end

`ifdef LED_SEQ_BOUNCE_EN
  // Chase direction register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir <= 1'b0;
    end else begin
      dir <= dir_n;
    end
  end
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: self-checking bench for led_sequencer (NUM_LEDS=4,
// CLOCK_DIV=4). Each clock, the expected outputs for the upcoming edge are
// computed by a behavioural model (step count since restart) and pushed to a
// scoreboard queue; they are popped and compared on the following falling
// edge. Directed checks cover the sequences listed for each scenario.

`timescale 1ns/1ps

module tb_led_sequencer;

  localparam int N       = 4;
  localparam int CLK_DIV = 4;

  typedef struct packed {
    logic [N-1:0] led;
    logic         step;
  } exp_t;

  logic         clock;
  logic         reset;
  logic [N-1:0] led_enable;
  logic [1:0]   mode;
  logic         hold;
  logic [N-1:0] led_output;
  logic         step_pulse;

  int   n_vec;
  int   n_err;
  exp_t sb[$];

  // Model state: registered mode and active (non-held) cycles since restart.
  logic [1:0] m_mode_q;
  int         m_k;

  logic [N-1:0] chase_tbl [7];

  led_sequencer #(
    .NUM_LEDS  (N),
    .CLOCK_DIV (CLK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .led_enable (led_enable),
    .mode       (mode),
    .hold       (hold),
    .led_output (led_output),
    .step_pulse (step_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after the next rising edge, given the inputs now applied.
  task automatic model_edge(input logic [1:0] md, input logic [N-1:0] en,
                            input logic hd, output exp_t e);
    int steps;
    int p;
    int pos;
    logic restart;
    restart  = (md != m_mode_q);
    m_mode_q = md;
    e.step   = 1'b0;
    if (restart || md == 2'b00) begin
      m_k = 0;
    end else if (!hd) begin
      m_k++;
      e.step = ((m_k % CLK_DIV) == 0);
    end
    steps = m_k / CLK_DIV;
`ifdef LED_SEQ_BOUNCE_EN
    p   = steps % (2 * N - 2);
    pos = (p < N) ? p : (2 * N - 2 - p);
`else
    p   = steps;
    pos = p % N;
`endif
    case (md)
      2'b00:   e.led = '0;
      2'b01:   e.led = (N'(1) << pos) & en;
      2'b10:   e.led = ((steps % 2) == 1) ? en : '0;
      default: e.led = '1;
    endcase
  endtask

  // One clock: push the expectation, let the edge happen, pop and compare.
  task automatic run_cycle(input string tag);
    exp_t e;
    exp_t got_e;
    model_edge(mode, led_enable, hold, e);
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
    end else begin
      got_e = sb.pop_front();
      check({tag, "_led"}, 32'(led_output), 32'(got_e.led));
      check({tag, "_step"}, 32'(step_pulse), 32'(got_e.step));
    end
  endtask

  task automatic run_n(input string tag, input int n);
    for (int i = 0; i < n; i++) run_cycle(tag);
  endtask

  task automatic model_reset();
    m_mode_q = 2'b00;
    m_k      = 0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef LED_SEQ_BOUNCE_EN
    chase_tbl[0] = 4'b0010; chase_tbl[1] = 4'b0100; chase_tbl[2] = 4'b1000;
    chase_tbl[3] = 4'b0100; chase_tbl[4] = 4'b0010; chase_tbl[5] = 4'b0001;
    chase_tbl[6] = 4'b0010;
`else
    chase_tbl[0] = 4'b0010; chase_tbl[1] = 4'b0100; chase_tbl[2] = 4'b1000;
    chase_tbl[3] = 4'b0001; chase_tbl[4] = 4'b0010; chase_tbl[5] = 4'b0100;
    chase_tbl[6] = 4'b1000;
`endif

    // Reset and off mode.
    reset      = 1'b0;
    mode       = 2'b00;
    led_enable = 4'b1111;
    hold       = 1'b0;
    model_reset();
    #1;
    check("rst_led", 32'(led_output), 32'h0);
    check("rst_step", 32'(step_pulse), 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    run_n("off", 40);

    // Chase: restart shows position 0, then one step every CLOCK_DIV clocks.
    mode = 2'b01;
    run_cycle("chase_rs");
    check("chase_start", 32'(led_output), 32'h1);
    for (int j = 0; j < 7; j++) begin
      run_n("chase", CLK_DIV);
      check("chase_seq", 32'(led_output), 32'(chase_tbl[j]));
      check("chase_pulse", 32'(step_pulse), 32'h1);
    end

    // Asynchronous reset in the middle of a step.
    run_n("chase", 2);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_led", 32'(led_output), 32'h0);
    check("async_rst_step", 32'(step_pulse), 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    run_cycle("post_rst");
    check("post_rst_start", 32'(led_output), 32'h1);
    run_n("post_rst", CLK_DIV);
    check("post_rst_step", 32'(led_output), 32'h2);

    // Chase with channel 2 disabled: its slot stays dark, timing unchanged.
    mode = 2'b00;
    run_cycle("dis_off");
    mode       = 2'b01;
    led_enable = 4'b1011;
    run_cycle("dis_rs");
    check("dis_start", 32'(led_output), 32'h1);
    run_n("dis", CLK_DIV);
    check("dis_p1", 32'(led_output), 32'h2);
    run_n("dis", CLK_DIV);
    check("dis_slot", 32'(led_output), 32'h0);
    check("dis_slot_pulse", 32'(step_pulse), 32'h1);
    run_n("dis", CLK_DIV);
    check("dis_p3", 32'(led_output), 32'h8);

    // Blink with hold stretching the lit phase by 10 clocks.
    mode       = 2'b10;
    led_enable = 4'b0101;
    run_cycle("blink_rs");
    check("blink_start", 32'(led_output), 32'h0);
    run_n("blink", CLK_DIV);
    check("blink_on", 32'(led_output), 32'h5);
    run_n("blink", 2);
    hold = 1'b1;
    run_n("blink_hold", 10);
    hold = 1'b0;
    run_cycle("blink");
    check("blink_still_on", 32'(led_output), 32'h5);
    run_cycle("blink");
    check("blink_stretch", 32'(led_output), 32'h0);
    check("blink_stretch_pulse", 32'(step_pulse), 32'h1);
    run_n("blink", CLK_DIV);
    check("blink_on2", 32'(led_output), 32'h5);

    // Hold and mode change together: restart happens, then the block holds.
    mode       = 2'b01;
    led_enable = 4'b1111;
    hold       = 1'b1;
    run_n("hold_rs", 9);
    check("hold_rs_pos0", 32'(led_output), 32'h1);
    hold = 1'b0;
    run_n("hold_rel", CLK_DIV);
    check("hold_rel_step", 32'(led_output), 32'h2);

    // Maintenance override mid-chase, then restart back into chase.
    run_n("pre_maint", 2);
    mode       = 2'b11;
    led_enable = 4'b0000;
    run_cycle("maint");
    check("maint_on", 32'(led_output), 32'hF);
    run_n("maint", 5);
    mode       = 2'b01;
    led_enable = 4'b1111;
    run_cycle("back_rs");
    check("back_start", 32'(led_output), 32'h1);
    run_n("back", CLK_DIV - 1);
    check("back_wait", 32'(led_output), 32'h1);
    run_cycle("back");
    check("back_step", 32'(led_output), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
